// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [0:0] {
        FQ_FETCH = 1'b0,
        FQ_DRAIN = 1'b1
    } fq_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fq_entry_t;

    // Sequential fetch address; wraps silently at the top of the address space.
    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + XLEN'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction-memory, redirect and IF/ID dequeue signals of the prefetch queue.
interface fetch_queue_if
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    logic            redirect;
    logic [XLEN-1:0] redirect_pc;

    logic            deq_ready;
    logic            deq_valid;
    logic [XLEN-1:0] deq_instr;
    logic [XLEN-1:0] deq_pc;
    logic [XLEN-1:0] deq_pc4;
    logic [CW-1:0]   count;

    // master: the fetch queue itself; slave: memory, EX and IF/ID around it
    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rvalid, imem_rdata,
        input  redirect, redirect_pc,
        input  deq_ready,
        output deq_valid, deq_instr, deq_pc, deq_pc4, count
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rvalid, imem_rdata,
        output redirect, redirect_pc,
        output deq_ready,
        input  deq_valid, deq_instr, deq_pc, deq_pc4, count
    );

endinterface

// File: rtl/sync_fifo.sv
// Small register-based FIFO with combinational head, flush and occupancy count.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra wrap bit on each pointer distinguishes full from empty.
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [AW:0]      used;

    assign used      = wr_ptr_reg - rd_ptr_reg;
    assign count     = CW'(used);
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign head_data = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: credit-limited in-order fetch, response buffering, redirect drain.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           _reset,
    fetch_queue_if.master  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [0:0] ST_FETCH = FQ_FETCH;
    localparam logic [0:0] ST_DRAIN = FQ_DRAIN;

    logic [0:0]      state_reg, state_next;
    logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
    logic [XLEN-1:0] resp_pc_reg, resp_pc_next;
    logic [CW-1:0]   outstanding_reg, outstanding_next;
    logic [CW-1:0]   discard_reg, discard_next;

    logic [CW-1:0]   fifo_count;
    logic [CW:0]     in_use;
    logic [CW-1:0]   remaining;
    logic            fifo_full, fifo_empty, fifo_srst;
    logic [$bits(fq_entry_t)-1:0] head_bits;
    fq_entry_t       head, push_entry;

    logic credit_ok, req, accept, rsp_ok, push, deq_valid, pop, stray_rvalid;

    // Queued entries plus in-flight requests never exceed DEPTH, so a push never finds the FIFO full.
    assign in_use    = {1'b0, fifo_count} + {1'b0, outstanding_reg};
    assign credit_ok = (in_use < (CW+1)'(DEPTH));

    assign req       = _reset && (state_reg == ST_FETCH) && !bus.redirect && credit_ok;
    assign accept    = req && bus.imem_ready;
    assign rsp_ok    = _reset && bus.imem_rvalid && (outstanding_reg != '0);
    assign push      = rsp_ok && (state_reg == ST_FETCH) && !bus.redirect;
    assign deq_valid = _reset && !fifo_empty && !bus.redirect;
    assign pop       = deq_valid && bus.deq_ready;

    // A response with nothing in flight is a protocol error; it is ignored rather than queued.
    assign stray_rvalid = _reset && bus.imem_rvalid && (outstanding_reg == '0);

    // Requests still owed a response after a redirect; a same-cycle response is already accounted for.
    assign remaining = outstanding_reg - CW'(rsp_ok);

    assign push_entry = '{pc: resp_pc_reg, instr: bus.imem_rdata};
    assign head       = fq_entry_t'(head_bits);
    assign fifo_srst  = !_reset;

    sync_fifo #(
        .WIDTH ($bits(fq_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .srst      (fifo_srst),
        .clear     (bus.redirect),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_bits),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_next       = state_reg;
        fetch_pc_next    = fetch_pc_reg;
        resp_pc_next     = resp_pc_reg;
        outstanding_next = outstanding_reg;
        discard_next     = discard_reg;

        if (bus.redirect) begin
            fetch_pc_next    = bus.redirect_pc;
            resp_pc_next     = bus.redirect_pc;
            outstanding_next = remaining;
            discard_next     = remaining;
            state_next       = (remaining != '0) ? ST_DRAIN : ST_FETCH;
        end else begin
            outstanding_next = outstanding_reg + CW'(accept) - CW'(rsp_ok);
            if (accept) begin
                fetch_pc_next = pc_plus4(fetch_pc_reg);
            end
            if (push) begin
                resp_pc_next = pc_plus4(resp_pc_reg);
            end
            if ((state_reg == ST_DRAIN) && rsp_ok) begin
                discard_next = discard_reg - CW'(1);
                if (discard_reg == CW'(1)) begin
                    state_next = ST_FETCH;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!_reset) begin
            state_reg       <= ST_FETCH;
            fetch_pc_reg    <= RESET_PC;
            resp_pc_reg     <= RESET_PC;
            outstanding_reg <= '0;
            discard_reg     <= '0;
        end else begin
            state_reg       <= state_next;
            fetch_pc_reg    <= fetch_pc_next;
            resp_pc_reg     <= resp_pc_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
        end
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = fetch_pc_reg;
    assign bus.deq_valid = deq_valid;
    assign bus.deq_instr = head.instr;
    assign bus.deq_pc    = head.pc;
    assign bus.deq_pc4   = pc_plus4(head.pc);
    assign bus.count     = fifo_count;

    assert property (@(posedge clk) disable iff (!_reset) push |-> !fifo_full);
    cover property (@(posedge clk) stray_rvalid);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: vector table for streaming/backpressure, hand sequences for redirect, drain and reset.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_queue_if #(.DEPTH(DEPTH)) fq ();

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk    (clk),
        ._reset (rst_n),
        .bus    (fq)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    typedef struct {
        logic        dr;
        logic        req;
        logic [31:0] addr;
        logic        dv;
        logic [31:0] pc;
        logic [2:0]  cnt;
    } vec_t;
    vec_t vecs[16];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    // Advance one clock and present any memory response that has come due.
    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
            fq.imem_rvalid = 1'b1;
            fq.imem_rdata  = instr_of(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            fq.imem_rvalid = 1'b0;
            fq.imem_rdata  = '0;
        end
    endtask

    // Sample at the falling edge and log requests the memory will accept.
    task automatic sample();
        @(negedge clk);
        if (fq.imem_req && fq.imem_ready) begin
            pend_addr.push_back(fq.imem_addr);
            pend_due.push_back(cyc + lat);
        end
    endtask

    task automatic do_reset(input int l);
        rst_n = 1'b0;
        fq.redirect = 1'b0;
        fq.redirect_pc = '0;
        fq.deq_ready = 1'b1;
        fq.imem_ready = 1'b1;
        lat = l;
        step();
        step();
        sample();
        chk("rst_req", fq.imem_req, 0);
        chk("rst_dv", fq.deq_valid, 0);
        chk("rst_cnt", fq.count, 0);
        step();
        rst_n = 1'b1;
        pend_addr.delete();
        pend_due.delete();
        fq.imem_rvalid = 1'b0;
        cyc = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        fq.imem_ready  = 1'b1;
        fq.imem_rvalid = 1'b0;
        fq.imem_rdata  = '0;
        fq.redirect    = 1'b0;
        fq.redirect_pc = '0;
        fq.deq_ready   = 1'b1;

        //             dr    req   addr   dv    pc     cnt
        vecs[0]  = '{1'b1, 1'b1, 32'd0,  1'b0, 32'd0,  3'd0};
        vecs[1]  = '{1'b1, 1'b1, 32'd4,  1'b0, 32'd0,  3'd0};
        vecs[2]  = '{1'b1, 1'b1, 32'd8,  1'b1, 32'd0,  3'd1};
        vecs[3]  = '{1'b1, 1'b1, 32'd12, 1'b1, 32'd4,  3'd1};
        vecs[4]  = '{1'b1, 1'b1, 32'd16, 1'b1, 32'd8,  3'd1};
        vecs[5]  = '{1'b0, 1'b1, 32'd20, 1'b1, 32'd12, 3'd1};
        vecs[6]  = '{1'b0, 1'b1, 32'd24, 1'b1, 32'd12, 3'd2};
        vecs[7]  = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd12, 3'd3};
        vecs[8]  = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd12, 3'd4};
        vecs[9]  = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd12, 3'd4};
        vecs[10] = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd12, 3'd4};
        vecs[11] = '{1'b0, 1'b1, 32'd28, 1'b1, 32'd16, 3'd3};
        vecs[12] = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd16, 3'd3};
        vecs[13] = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd16, 3'd4};
        vecs[14] = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd16, 3'd4};
        vecs[15] = '{1'b1, 1'b1, 32'd32, 1'b1, 32'd20, 3'd3};

        // Streaming with 1-cycle memory, then backpressure until the credits run out
        do_reset(1);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) step();
            fq.deq_ready = vecs[i].dr;
            sample();
            chk("t_req", fq.imem_req, vecs[i].req);
            if (vecs[i].req) chk("t_addr", fq.imem_addr, vecs[i].addr);
            chk("t_dv", fq.deq_valid, vecs[i].dv);
            if (vecs[i].dv) begin
                chk("t_pc", fq.deq_pc, vecs[i].pc);
                chk("t_pc4", fq.deq_pc4, vecs[i].pc + 32'd4);
                chk("t_instr", fq.deq_instr, instr_of(vecs[i].pc));
            end
            chk("t_cnt", fq.count, vecs[i].cnt);
            $display("vec %0d req=%b addr=%h dv=%b pc=%h cnt=%0d", i, fq.imem_req, fq.imem_addr,
                     fq.deq_valid, fq.deq_pc, fq.count);
        end

        // Redirect with two requests in flight on a 3-cycle memory
        do_reset(3);
        sample();
        chk("a_addr0", fq.imem_addr, 32'h0);
        step(); sample();
        chk("a_addr1", fq.imem_addr, 32'h4);
        step(); fq.redirect = 1'b1; fq.redirect_pc = 32'h100; sample();
        chk("a_req_sup", fq.imem_req, 0);
        step(); fq.redirect = 1'b0; sample();
        chk("a_state_drain", dut.state_reg, 1);
        chk("a_cnt", fq.count, 0);
        chk("a_req_drain", fq.imem_req, 0);
        step(); sample();
        chk("a_req_drain2", fq.imem_req, 0);
        step(); sample();
        chk("a_state_fetch", dut.state_reg, 0);
        chk("a_req_new", fq.imem_req, 1);
        chk("a_addr_new", fq.imem_addr, 32'h100);
        for (int k = 0; k < 3; k++) begin
            step(); sample();
            chk("a_dv_wait", fq.deq_valid, 0);
        end
        step(); sample();
        chk("a_dv", fq.deq_valid, 1);
        chk("a_pc", fq.deq_pc, 32'h100);
        chk("a_instr", fq.deq_instr, instr_of(32'h100));
        $display("seq A redirect 0x100 done");

        // Redirect coinciding with the only stale response
        do_reset(1);
        sample();
        chk("b_addr0", fq.imem_addr, 32'h0);
        step(); fq.redirect = 1'b1; fq.redirect_pc = 32'h40; sample();
        chk("b_req_sup", fq.imem_req, 0);
        step(); fq.redirect = 1'b0; sample();
        chk("b_state", dut.state_reg, 0);
        chk("b_req", fq.imem_req, 1);
        chk("b_addr", fq.imem_addr, 32'h40);
        chk("b_dv0", fq.deq_valid, 0);
        chk("b_cnt", fq.count, 0);
        step(); sample();
        chk("b_dv1", fq.deq_valid, 0);
        step(); sample();
        chk("b_dv", fq.deq_valid, 1);
        chk("b_pc", fq.deq_pc, 32'h40);
        chk("b_instr", fq.deq_instr, instr_of(32'h40));
        $display("seq B redirect 0x40 done");

        // Second redirect while draining
        do_reset(3);
        sample();
        step(); fq.redirect = 1'b1; fq.redirect_pc = 32'h200; sample();
        chk("c_req_sup", fq.imem_req, 0);
        step(); fq.redirect_pc = 32'h300; sample();
        chk("c_state1", dut.state_reg, 1);
        chk("c_req1", fq.imem_req, 0);
        step(); fq.redirect = 1'b0; sample();
        chk("c_state2", dut.state_reg, 1);
        step(); sample();
        chk("c_state3", dut.state_reg, 0);
        chk("c_req", fq.imem_req, 1);
        chk("c_addr", fq.imem_addr, 32'h300);
        step(); sample();
        chk("c_addr2", fq.imem_addr, 32'h304);
        step(); sample();
        step(); sample();
        chk("c_dv0", fq.deq_valid, 0);
        step(); sample();
        chk("c_dv", fq.deq_valid, 1);
        chk("c_pc", fq.deq_pc, 32'h300);
        chk("c_instr", fq.deq_instr, instr_of(32'h300));
        $display("seq C redirect 0x200->0x300 done");

        // Reset in the middle of a drain, then a late stray response
        do_reset(3);
        sample();
        step(); sample();
        step(); fq.redirect = 1'b1; fq.redirect_pc = 32'h500; sample();
        chk("d_req_sup", fq.imem_req, 0);
        step(); fq.redirect = 1'b0; rst_n = 1'b0; sample();
        chk("d_req_rst", fq.imem_req, 0);
        chk("d_dv_rst", fq.deq_valid, 0);
        chk("d_state_pre", dut.state_reg, 1);
        step(); sample();
        chk("d_state_rst", dut.state_reg, 0);
        chk("d_outs_rst", dut.outstanding_reg, 0);
        chk("d_cnt_rst", fq.count, 0);
        chk("d_req_rst2", fq.imem_req, 0);
        step();
        rst_n = 1'b1;
        pend_addr.delete();
        pend_due.delete();
        lat = 1;
        fq.imem_rvalid = 1'b1;
        fq.imem_rdata  = 32'hBAD0_0000;
        sample();
        chk("d_stray_flag", dut.stray_rvalid, 1);
        chk("d_req", fq.imem_req, 1);
        chk("d_addr", fq.imem_addr, RESET_PC);
        step(); sample();
        chk("d_cnt_nostray", fq.count, 0);
        chk("d_stray_clr", dut.stray_rvalid, 0);
        step(); sample();
        chk("d_dv", fq.deq_valid, 1);
        chk("d_pc", fq.deq_pc, RESET_PC);
        chk("d_instr", fq.deq_instr, instr_of(RESET_PC));
        chk("d_cnt", fq.count, 1);
        $display("seq D reset mid-drain done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction prefetch stage between the instruction memory and the IF/ID pipeline register.
- Issues in-order word fetch requests to an instruction memory with a variable-latency req/ready + rvalid handshake, and buffers returned instructions with their PC in a small FIFO.
- Presents one instruction per cycle to IF/ID, which pulls with a ready signal equal to the inverse of its stall.
- A branch/jump redirect from EX flushes the queue and drops in-flight responses.

Parameters:
- DEPTH, 4, number of queue entries and the maximum number of outstanding requests; must be a power of two, ≥2.
- RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
- clk  in  1  clock
- _reset  in  1  synchronous, active-low reset
- imem_req  out  1  fetch request valid
- imem_addr  out  32  byte address of the request (word aligned)
- imem_ready  in  1  memory accepts the request this cycle
- imem_rvalid  in  1  response data valid; responses are in order
- imem_rdata  in  32  returned instruction
- redirect  in  1  taken branch/jump from EX
- redirect_pc  in  32  new fetch address (word aligned)
- deq_ready  in  1  IF/ID can accept an instruction (not stalled)
- deq_valid  out  1  head entry valid
- deq_instr  out  32  head instruction
- deq_pc  out  32  head PC
- deq_pc4  out  32  head PC + 4
- count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (_reset=0 at posedge): fetch_pc=RESET_PC, resp_pc=RESET_PC, outstanding=0, discard=0, queue empty, state=FETCH. While reset is asserted, imem_req=0 and deq_valid=0. Reset overrides redirect and all in-flight transactions.
- State FETCH:
  - imem_req = !redirect && (count + outstanding < DEPTH).
  - imem_addr = fetch_pc.
  - Accept when imem_req && imem_ready: fetch_pc += 4, outstanding += 1.
- Response handling in FETCH:
  - imem_rvalid: push {resp_pc, imem_rdata}, resp_pc += 4, outstanding -= 1.
  - The credit rule guarantees no overflow. imem_rvalid with outstanding==0 is a protocol error; cover it with an assertion.
- Dequeue: deq_valid = (count!=0) && !redirect. Pop when deq_valid && deq_ready.
- Latency:
  - Response at edge t → deq_valid visible in the cycle after edge t. No bypass from imem_rdata to deq.
  - Minimum redirect-to-deq latency is 3 cycles with 1-cycle memory.
- Same-cycle push and pop: both take effect; count unchanged. A full queue with a pop frees a credit, so a request may issue next cycle.
- Redirect (any state, highest priority after reset):
  - Queue cleared, count=0, no pop that cycle.
  - fetch_pc = resp_pc = redirect_pc.
  - discard = outstanding − (imem_rvalid ? 1 : 0), counting requests not yet responded to. A response arriving that same cycle is dropped.
  - Next state = DRAIN if discard>0, else FETCH.
  - The request is suppressed that cycle.
- State DRAIN:
  - imem_req=0. Each imem_rvalid is dropped: discard -= 1, outstanding -= 1.
  - When discard reaches 0 (including the cycle of the last drop) → FETCH. The first new request issues in the next cycle.
  - A redirect in DRAIN recomputes discard and stays in DRAIN if it is still non-zero.
- Arithmetic: PC additions are modulo 2^32; wrap from 32'hFFFF_FFFC to 0 silently.
- Pointers: read/write pointers are $clog2(DEPTH) bits and wrap naturally. count is derived from pointer plus an extra wrap bit.

Decomposition:
- Package fetch_pkg: XLEN=32, INSTR_BYTES=4, typedef enum {FQ_FETCH, FQ_DRAIN} fq_state_t, typedef struct packed {logic[31:0] pc; logic[31:0] instr;} fq_entry_t.
- Sub-module sync_fifo (parameterised width/depth, push/pop/clear, count): the storage. fetch_queue holds the FSM, credit counters and PC registers.

Test Plan:
- Reset with 1-cycle memory and deq_ready=1 → addresses 0,4,8,…; deq_pc sequence 0,4,8; first deq_valid 2 cycles after the first request; deq_pc4 = deq_pc+4.
- deq_ready=0, zero-latency ready, 1-cycle rvalid → count saturates at 4, imem_req drops once count+outstanding=4; one pop → exactly one new request at the next fetch_pc.
- 3-cycle memory, redirect to 32'h100 with 2 outstanding → queue empties, state=DRAIN, next 2 rvalids dropped, then the first request addr=32'h100 and deq_pc=32'h100.
- Redirect in the same cycle as the last stale rvalid (outstanding=1) → discard=0, stays in FETCH, next request addr=redirect_pc, stale word never dequeued.
- Redirect to 32'h200 while in DRAIN, then redirect to 32'h300 → only 32'h300 fetched; no 32'h200 instruction appears at deq.
- _reset low mid-DRAIN with 2 outstanding → all outputs at reset values; after release, fetch from RESET_PC; late stale rvalid flagged by the assertion (bench marks it as expected).
